// File: rtl/servo_cmd_pkg.sv
// Shared definitions for the UART servo command parser.
// Holds the frame parser state encoding, the sync byte value, the
// frame lengths for both build flavours and the setpoint width.
// No ports; imported by uart_servo_cmd_parser and servo_cmd_timeout.
package servo_cmd_pkg;

  typedef enum logic [2:0] {
    S_SYNC,
    S_ID,
    S_HI,
    S_LO,
    S_CHK
  } cmdState_t;

  localparam logic [7:0] SYNC_BYTE       = 8'hFF;
  localparam int         FRAME_LEN_CHK   = 5;
  localparam int         FRAME_LEN_NOCHK = 4;
  localparam int         POS_W           = 16;

endpackage

// File: rtl/servo_cmd_timeout.sv
// Inter-byte timeout counter for the servo command parser.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : restart counting from zero (a byte arrived)
//   enable     : count only while a frame is partially received
//   expired    : one-cycle pulse when the idle limit is reached with no byte
module servo_cmd_timeout
  import servo_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idleCount;

  // A byte arriving in the expiry cycle takes priority, so clear masks expiry.
  always_comb begin
    expired = enable && !clear && (idleCount == LIMIT);
  end

  // Count idle clocks inside a frame; restart on any byte, outside a frame,
  // or once the limit fires so the next frame starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idleCount <= '0;
    end else if (clear || !enable || expired) begin
      idleCount <= '0;
    end else begin
      idleCount <= idleCount + 1'b1;
    end
  end

endmodule

// File: rtl/uart_servo_cmd_parser.sv
// UART servo command parser.
// Assembles frames FF, ID, POS_HI, POS_LO[, CHK] from received bytes and
// updates per-servo setpoints clamped to [POS_MIN, POS_MAX]. Frames with a
// bad checksum, an out-of-range ID, or that stall mid-frame are rejected.
// Build option: define SERVO_CMD_CHECKSUM_EN for the 5-byte frame with an
// XOR checksum; left undefined, frames are 4 bytes and carry no checksum.
// Ports:
//   clk, rst_n            : clock and asynchronous active-low reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   servo0_pos/servo1_pos : current setpoints
//   pos_update            : bit n pulses in the cycle after servo n is written
//   frame_err             : one-cycle pulse per rejected frame
//   err_count             : saturating count of rejected frames
module uart_servo_cmd_parser
  import servo_cmd_pkg::*;
#(
  parameter int              NUM_SERVOS     = 2,
  parameter logic [POS_W-1:0] POS_MIN       = 16'd1000,
  parameter logic [POS_W-1:0] POS_MAX       = 16'd2000,
  parameter logic [POS_W-1:0] POS_RESET     = 16'd1500,
  parameter int              TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [POS_W-1:0] servo0_pos,
  output logic [POS_W-1:0] servo1_pos,
  output logic [1:0]       pos_update,
  output logic             frame_err,
  output logic [7:0]       err_count
);

  cmdState_t        state;
  cmdState_t        stateNext;
  logic [7:0]       idReg;
  logic [7:0]       hiReg;
`ifdef SERVO_CMD_CHECKSUM_EN
  logic [7:0]       loReg;
`endif
  logic             timeoutHit;
  logic             lastByte;
  logic             chkOk;
  logic             idOk;
  logic             commitNow;
  logic             errNow;
  logic [POS_W-1:0] posRaw;
  logic [POS_W-1:0] posClamped;
  logic [1:0]       updNext;

  servo_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_valid),
    .enable (state != S_SYNC),
    .expired(timeoutHit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_SYNC;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; a stalled frame drops back to hunting for sync.
  // 0xFF is only treated as sync while in S_SYNC, so it is legal payload.
  always_comb begin
    stateNext = state;
    if (timeoutHit) begin
      stateNext = S_SYNC;
    end else if (rx_valid) begin
      case (state)
        S_SYNC:  stateNext = (rx_data == SYNC_BYTE) ? S_ID : S_SYNC;
        S_ID:    stateNext = S_HI;
        S_HI:    stateNext = S_LO;
`ifdef SERVO_CMD_CHECKSUM_EN
        S_LO:    stateNext = S_CHK;
`else
        S_LO:    stateNext = S_SYNC;
`endif
        S_CHK:   stateNext = S_SYNC;
        default: stateNext = S_SYNC;
      endcase
    end
  end

  // Capture payload bytes as they arrive. The final byte of the frame is
  // used directly from rx_data, so it never needs its own register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idReg <= '0;
      hiReg <= '0;
`ifdef SERVO_CMD_CHECKSUM_EN
      loReg <= '0;
`endif
    end else if (rx_valid) begin
      if (state == S_ID) idReg <= rx_data;
      if (state == S_HI) hiReg <= rx_data;
`ifdef SERVO_CMD_CHECKSUM_EN
      if (state == S_LO) loReg <= rx_data;
`endif
    end
  end

  // Frame verdict: on the final byte decide between commit and reject, then
  // clamp the requested position and pick which servo's update bit fires.
  always_comb begin
`ifdef SERVO_CMD_CHECKSUM_EN
    lastByte = rx_valid && (state == S_CHK);
    posRaw   = {hiReg, loReg};
    chkOk    = (rx_data == (idReg ^ hiReg ^ loReg));
`else
    lastByte = rx_valid && (state == S_LO);
    posRaw   = {hiReg, rx_data};
    chkOk    = 1'b1;
`endif
    idOk      = int'(idReg) < NUM_SERVOS;
    commitNow = lastByte && chkOk && idOk;
    errNow    = (lastByte && !(chkOk && idOk)) || timeoutHit;
    if (posRaw < POS_MIN) begin
      posClamped = POS_MIN;
    end else if (posRaw > POS_MAX) begin
      posClamped = POS_MAX;
    end else begin
      posClamped = posRaw;
    end
    updNext = 2'b00;
    if (commitNow) begin
      updNext[idReg[0]] = 1'b1;
    end
  end

  // Registered outputs: setpoints, update/error pulses and the saturating
  // error counter all change on the edge that consumes the final byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      servo0_pos <= POS_RESET;
      servo1_pos <= POS_RESET;
      pos_update <= 2'b00;
      frame_err  <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      pos_update <= updNext;
      frame_err  <= errNow;
      if (commitNow && (idReg == 8'd0)) servo0_pos <= posClamped;
      if (commitNow && (idReg == 8'd1)) servo1_pos <= posClamped;
      if (errNow && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule
